// File: rtl/uart_tx_model.sv
`default_nettype none
// ============================================================================
// uart_tx_model : FIFO-buffered UART transmitter that drives a serial line.
// Define UART_TX_MODEL_PARITY_EN to add an even parity bit after the data.
// Revision: 1.0
// ============================================================================
module uart_tx_model #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0]       tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(STOP_BITS * CPB + 1);
  localparam int BW   = $clog2(PAYLOAD_BITS);

  localparam logic [CW-1:0]   BIT_LAST     = CW'(CPB - 1);
  localparam logic [CW-1:0]   STOP_LAST    = CW'(STOP_BITS * CPB - 1);
  localparam logic [BW-1:0]   PAYLOAD_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [CNTW-1:0] DEPTH_VAL    = CNTW'(FIFO_DEPTH);

  if (CPB < 2) begin : g_bad_cpb
    $fatal(1, "uart_tx_model: CLK_HZ / BIT_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_MODEL_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO storage
  logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CNTW-1:0]         r_count;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_can_pop;
  logic [PAYLOAD_BITS-1:0] w_head;

  // Frame sequencer
  state_t                  r_state, w_state_next;
  logic [CW-1:0]           r_cnt, w_cnt_next;
  logic [BW-1:0]           r_bit, w_bit_next;
  logic [PAYLOAD_BITS-1:0] r_shift, w_shift_next;
  logic                    r_txd, w_txd_next;
  logic                    r_busy;
  logic                    r_done, w_done_next;
`ifdef UART_TX_MODEL_PARITY_EN
  logic                    r_parity;
`endif

  assign tx_ready   = (r_count < DEPTH_VAL);
  assign fifo_count = r_count;
  assign uart_txd   = r_txd;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;

  assign w_push    = tx_valid && tx_ready;
  assign w_can_pop = uart_tx_en && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_txd   <= w_txd_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_done_next;
    end
  end

`ifdef UART_TX_MODEL_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= ^w_head;
    end
  end
`endif

  // Next-state logic; r_cnt counts clocks spent in the current bit (or stop period).
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (w_can_pop) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = r_shift >> 1;
          if (r_bit == PAYLOAD_LAST) begin
`ifdef UART_TX_MODEL_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end
      end
`ifdef UART_TX_MODEL_PARITY_EN
      S_PARITY: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == STOP_LAST) begin
          w_cnt_next = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (w_can_pop) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Line level and done pulse are computed for the next state so they stay registered.
  always_comb begin
    w_txd_next = 1'b1;
    case (w_state_next)
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_MODEL_PARITY_EN
      S_PARITY: w_txd_next = r_parity;
`endif
      default:  w_txd_next = 1'b1;
    endcase
    w_done_next = (w_state_next == S_STOP) && (w_cnt_next == STOP_LAST);
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_model.sv
`default_nettype none
// Directed bench for uart_tx_model at CPB=10: frame shape, latency, FIFO
// back-pressure, back-to-back chaining, mid-frame reset and enable drop.
module tb_uart_tx_model;

`ifdef UART_TX_MODEL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB   = 10;
  localparam int FRAME = (10 + P) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_txd;
  logic       tx_busy;
  logic       tx_done;
  logic [4:0] fifo_count;

  int total  = 0;
  int passed = 0;

  uart_tx_model #(
    .BIT_RATE     (100_000),
    .CLK_HZ       (1_000_000),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_tx_en (uart_tx_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         cnt_at_start;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // All tasks are entered and left at a negedge.
  task automatic push(input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int g = 0; g < 20 && !acc; g++) begin
      acc = tx_ready;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("push_accept", acc, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start();
    logic seen;
    seen = 1'b0;
    for (int g = 0; g < 10 && !seen; g++) begin
      @(negedge clk);
      seen = (uart_txd == 1'b0);
    end
    chk("start_seen", seen, 1);
  endtask

  // Called while the current negedge is the first cycle of the frame.
  task automatic check_frame(input logic [7:0] d, input logic par, input int exp_cnt, input int drop_at);
    logic [10:0] obs;
    logic [10:0] exp_line;
    logic        glitch;
    int          dones;
    int          done_at;
    obs      = '1;
    exp_line = '1;
    glitch   = 1'b0;
    dones    = 0;
    done_at  = -1;
    exp_line[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_line[1+i] = d[i];
`ifdef UART_TX_MODEL_PARITY_EN
    exp_line[9] = par;
`else
    exp_line[10] = exp_line[10] | par;
`endif
    chk("start_count", fifo_count, exp_cnt);
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (c % CPB == 0) obs[c / CPB] = uart_txd;
      else if (uart_txd !== obs[c / CPB]) glitch = 1'b1;
      if (tx_done) begin
        dones++;
        done_at = c;
      end
      if (c == drop_at) uart_tx_en = 1'b0;
    end
    chk("frame_bits", obs, exp_line);
    chk("bit_stable", glitch, 0);
    chk("done_count", dones, 1);
    chk("done_cycle", done_at, FRAME - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [6];
    logic [7:0] d;
    logic bad;
    tbl[0] = '{8'h41, 1'b0, 5};
    tbl[1] = '{8'h42, 1'b0, 4};
    tbl[2] = '{8'h0A, 1'b0, 3};
    tbl[3] = '{8'h07, 1'b1, 2};
    tbl[4] = '{8'h03, 1'b0, 1};
    tbl[5] = '{8'h80, 1'b1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_count", fifo_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte: count visible one cycle after push, line falls the cycle after
    uart_tx_en = 1'b1;
    push(8'h55);
    chk("lat_count", fifo_count, 1);
    chk("lat_txd_high", uart_txd, 1);
    @(negedge clk);
    chk("lat_txd_fall", uart_txd, 0);
    chk("lat_busy", tx_busy, 1);
    check_frame(8'h55, 1'b0, 0, -1);
    @(negedge clk);
    chk("after55_busy", tx_busy, 0);
    chk("after55_txd", uart_txd, 1);

    // Table: queue all, then send back-to-back
    uart_tx_en = 1'b0;
    for (int i = 0; i < 6; i++) push(tbl[i].data);
    chk("tbl_count", fifo_count, 6);
    chk("tbl_idle_txd", uart_txd, 1);
    uart_tx_en = 1'b1;
    wait_start();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check_frame(tbl[i].data, tbl[i].par, tbl[i].cnt_at_start, -1);
    end
    @(negedge clk);
    chk("tbl_end_busy", tx_busy, 0);

    // FIFO full with transmitter disabled
    do_reset();
    uart_tx_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 19 + 5);
      push(d);
    end
    chk("full_count", fifo_count, 16);
    chk("full_ready", tx_ready, 0);
    chk("full_txd", uart_txd, 1);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_no_push", fifo_count, 16);
    tx_valid = 1'b0;
    uart_tx_en = 1'b1;
    wait_start();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      d = 8'(i * 19 + 5);
      check_frame(d, ^d, 15 - i, -1);
    end
    @(negedge clk);
    chk("full_end_count", fifo_count, 0);

    // Reset at cycle 45 of a 0x00 frame with three queued
    do_reset();
    uart_tx_en = 1'b0;
    push(8'h00); push(8'h11); push(8'h22); push(8'h33);
    uart_tx_en = 1'b1;
    wait_start();
    repeat (44) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_txd", uart_txd, 1);
    chk("mrst_count", fifo_count, 0);
    chk("mrst_busy", tx_busy, 0);
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    chk("mrst_quiet", bad, 0);

    // Enable dropped at cycle 30 with two queued
    do_reset();
    uart_tx_en = 1'b0;
    push(8'h5A); push(8'h12); push(8'h34);
    uart_tx_en = 1'b1;
    wait_start();
    check_frame(8'h5A, 1'b0, 2, 29);
    @(negedge clk);
    chk("endrop_busy", tx_busy, 0);
    chk("endrop_txd", uart_txd, 1);
    chk("endrop_count", fifo_count, 2);
    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    chk("endrop_quiet", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
